chacha20_ctrl: RTL and testbench
================================

// Module: chacha20_ctrl
// PURPOSE
//  Session/block sequencer for the ChaCha20 core. Fetches a 256-bit key and 96-bit nonce from the TRNG,
//  builds the 512-bit initial state, and runs the core once per 512-bit host block.
//  XORs the keystream with the block and returns the result.
//  Owns the block counter; sits between the host data path, the TRNG and one ChaCha20 core instance.
// PARAMETERS
//  KEY_WORDS     8     32-bit TRNG words loaded into key (s4..s11)
//  NONCE_WORDS   3     32-bit TRNG words loaded into nonce (s13..s15)
//  INIT_COUNTER  1     value loaded into s12 after every successful rekey
//  TRNG_TIMEOUT  1024  max cycles trng_request may stay high without trng_ready before error
// PORTS
//  clk             in   1    clock
//  rst_n           in   1    asynchronous active-low reset
//  rekey           in   1    pulse: discard session, fetch new key+nonce
//  mode            in   1    enc/dec; forwarded to core_mode (XOR is identical both ways)
//  keyed           out  1    valid key/nonce held, counter not exhausted
//  busy            out  1    state != IDLE/KEYED/ERROR
//  err_trng        out  1    sticky: TRNG timeout
//  err_ctr         out  1    sticky: block counter exhausted
//  in_valid        in   1    host block valid
//  in_ready        out  1    controller accepts block
//  in_data         in   512  plaintext/ciphertext block; word i = in_data[32i+31:32i]
//  out_valid       out  1    result valid
//  out_ready       in   1    host accepts result
//  out_data        out  512  in_data XOR keystream
//  core_start      out  1    one-cycle start pulse to core
//  core_busy       in   1    core busy
//  core_done       in   1    core keystream valid (pulse)
//  core_mode       out  1    = mode
//  core_in_state   out  512  s[i] at [32i+31:32i]
//  core_out_state  in   512  keystream block (core includes final state add)
//  trng_request    out  1    TRNG word request
//  trng_data       in   32   TRNG word
//  trng_ready      in   1    trng_data valid this cycle
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; key, nonce, counter and data registers cleared to 0.
//  Reset mid-operation aborts everything, with no partial output.
//  State layout: s0..s3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574.
//   s4..s11 = key, in TRNG order. s12 = counter. s13..s15 = nonce, in TRNG order.
//  IDLE:   rekey -> FETCH.
//  FETCH:  on entry, key/nonce/word count/timeout counter are zeroed; trng_request=1 (registered).
//   Each cycle with trng_ready=1 stores trng_data as the next word and resets the timeout counter.
//   When word KEY_WORDS+NONCE_WORDS-1 is captured, trng_request drops the next cycle,
//   counter <= INIT_COUNTER, clear err_ctr, -> KEYED.
//   If the timeout counter reaches TRNG_TIMEOUT: err_trng=1, key/nonce zeroed -> ERROR.
//  KEYED:  keyed=1; in_ready=1. On in_valid&in_ready: latch in_data -> START. rekey -> FETCH (priority over in_valid).
//  START:  core_start=1 for exactly 1 cycle with core_in_state stable -> WAIT.
//   core_in_state stays stable until core_done.
//  WAIT:   on core_done: out_data <= latched in_data ^ core_out_state; out_valid=1 -> OUTPUT.
//  OUTPUT: out_valid and out_data are held until out_ready.
//   On handshake: if counter==0xFFFFFFFF, set err_ctr=1 and keyed=0 -> ERROR (no wrap to 0).
//   Otherwise counter+1 -> KEYED.
//  ERROR:  in_ready=0. Only rekey exits (-> FETCH).
//   err_trng is cleared on FETCH entry. err_ctr is cleared on a successful FETCH completion.
//  rekey during FETCH restarts the fetch: word count=0, key/nonce cleared.
//   rekey during START/WAIT/OUTPUT is latched pending and taken after the output handshake,
//   instead of the KEYED/ERROR transition.
//  Latency: in handshake at T -> core_start at T+1 -> out_valid 1 cycle after core_done.
//  in_ready is never high while busy=1. There is never more than one block in flight.
//  core_done outside WAIT is ignored.
//  Counter arithmetic: 32-bit unsigned, +1 per accepted output.
// TESTING
//  1. RFC 8439 vector: TRNG words 0x03020100..0x1f1e1d1c, then 0x09000000, 0x4a000000, 0x00000000; in_data=0.
//     Required: out_data[31:0]=0xe4e7f110 and core_in_state[415:384]=1.
//  2. Stall: trng_ready low 1023 cycles mid-fetch -> fetch completes.
//     trng_ready low 1024 cycles -> err_trng=1, state ERROR, trng_request=0.
//  3. Backpressure: out_ready low for 50 cycles -> out_valid/out_data stable, in_ready=0.
//     Then 3 back-to-back blocks -> s12 = 1, 2, 3.
//  4. Counter exhaustion: force counter 0xFFFFFFFF, send 1 block -> result valid, then err_ctr=1 and in_ready=0.
//     rekey -> counter=1, err_ctr=0.
//  5. rekey pulsed during WAIT -> current block output unchanged, then FETCH with trng_request=1.
//  6. rst_n low during WAIT -> all outputs 0 immediately; no out_valid after release.

Source files
------------

// File: rtl/chacha20_ctrl.sv
// chacha20_ctrl: session/block sequencer around one ChaCha20 core.
// Pulls key and nonce words from the TRNG, owns the 32-bit block counter,
// runs the core once per host block and returns block XOR keystream.
//
// state  | meaning
// IDLE   | no session since reset
// FETCH  | requesting key/nonce words from the TRNG
// KEYED  | session valid, waiting for a host block
// START  | pulse core_start once the core is free
// WAIT   | core running, waiting for core_done
// OUTPUT | result held until the host takes it
// ERROR  | TRNG timeout or counter exhausted; only rekey leaves
module chacha20_ctrl #(
    parameter int          KEY_WORDS    = 8,
    parameter int          NONCE_WORDS  = 3,
    parameter logic [31:0] INIT_COUNTER = 32'd1,
    parameter int          TRNG_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rekey,
    input  logic         mode,
    output logic         keyed,
    output logic         busy,
    output logic         err_trng,
    output logic         err_ctr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_data,
    output logic         core_start,
    input  logic         core_busy,
    input  logic         core_done,
    output logic         core_mode,
    output logic [511:0] core_in_state,
    input  logic [511:0] core_out_state,
    output logic         trng_request,
    input  logic [31:0]  trng_data,
    input  logic         trng_ready
);

    localparam int NW  = KEY_WORDS + NONCE_WORDS;
    localparam int WCW = $clog2(NW);
    localparam int TOW = $clog2(TRNG_TIMEOUT);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(NW - 1);
    localparam logic [TOW-1:0] TO_LOAD   = TOW'(TRNG_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, KEYED, START, WAIT, OUTPUT, ERROR
    } state_t;

    state_t state, state_nx;

    // key words first, then nonce words, in the order the TRNG delivered them
    logic [31:0]    words [NW];
    logic [WCW-1:0] word_cnt;
    logic [TOW-1:0] tmo;
    logic [31:0]    counter;
    logic [511:0]   blk;
    logic [511:0]   init_state;
    logic           rekey_pend;
    logic           rekey_any;
    logic           word_take;
    logic           fetch_done;
    logic           trng_timeout;
    logic           out_take;
    logic           fetch_entry;

    assign rekey_any    = rekey | rekey_pend;
    assign word_take    = (state == FETCH) && !rekey && trng_ready;
    assign fetch_done   = word_take && (word_cnt == LAST_WORD);
    assign trng_timeout = (state == FETCH) && !rekey && !trng_ready && (tmo == '0);
    assign out_take     = (state == OUTPUT) && out_ready;
    // a rekey inside FETCH re-enters FETCH and restarts the word sequence
    assign fetch_entry  = (state_nx == FETCH) && ((state != FETCH) || rekey);
    assign core_mode    = mode;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state decode and the purely state-derived handshake outputs
    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        core_start = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (rekey) state_nx = FETCH;
            end
            FETCH: begin
                if (rekey)             state_nx = FETCH;
                else if (fetch_done)   state_nx = KEYED;
                else if (trng_timeout) state_nx = ERROR;
            end
            KEYED: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (rekey)         state_nx = FETCH;
                else if (in_valid) state_nx = START;
            end
            START: begin
                // never start a core that is still busy with something else
                core_start = !core_busy;
                if (!core_busy) state_nx = WAIT;
            end
            WAIT: begin
                if (core_done) state_nx = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) begin
                    if (rekey_any)           state_nx = FETCH;
                    else if (counter == '1)  state_nx = ERROR;
                    else                     state_nx = KEYED;
                end
            end
            ERROR: begin
                busy = 1'b0;
                if (rekey) state_nx = FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end

    // session registers: TRNG fetch, timeout down-counter, block counter, flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) words[i] <= '0;
            word_cnt     <= '0;
            tmo          <= '0;
            counter      <= '0;
            keyed        <= 1'b0;
            err_trng     <= 1'b0;
            err_ctr      <= 1'b0;
            trng_request <= 1'b0;
        end else begin
            trng_request <= (state_nx == FETCH);
            if (fetch_entry) begin
                for (int i = 0; i < NW; i++) words[i] <= '0;
                word_cnt <= '0;
                tmo      <= TO_LOAD;
                err_trng <= 1'b0;
                keyed    <= 1'b0;
            end else if (word_take) begin
                words[word_cnt] <= trng_data;
                word_cnt        <= word_cnt + 1'b1;
                tmo             <= TO_LOAD;
                if (fetch_done) begin
                    counter <= INIT_COUNTER;
                    err_ctr <= 1'b0;
                    keyed   <= 1'b1;
                end
            end else if (trng_timeout) begin
                for (int i = 0; i < NW; i++) words[i] <= '0;
                err_trng <= 1'b1;
            end else if (state == FETCH) begin
                tmo <= tmo - 1'b1;
            end
            // the counter saturates: the last value is used once, then the session dies
            if (out_take) begin
                if (counter == '1) begin
                    err_ctr <= 1'b1;
                    keyed   <= 1'b0;
                end else begin
                    counter <= counter + 1'b1;
                end
            end
        end
    end

    // rekey seen while a block is in flight is deferred to the output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rekey_pend <= 1'b0;
        end else if (out_take) begin
            rekey_pend <= 1'b0;
        end else if (rekey && ((state == START) || (state == WAIT) || (state == OUTPUT))) begin
            rekey_pend <= 1'b1;
        end
    end

    // host block latch and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if ((state == KEYED) && in_valid && !rekey) blk <= in_data;
            if ((state == WAIT) && core_done) begin
                out_data  <= blk ^ core_out_state;
                out_valid <= 1'b1;
            end else if (out_take) begin
                out_valid <= 1'b0;
            end
        end
    end

    // initial state assembly; driven to the core only while a block is in
    // flight so key material is not exposed on the bus at other times
    always_comb begin
        init_state            = '0;
        init_state[31:0]      = 32'h6170_7865;
        init_state[63:32]     = 32'h3320_646e;
        init_state[95:64]     = 32'h7962_2d32;
        init_state[127:96]    = 32'h6b20_6574;
        for (int i = 0; i < KEY_WORDS; i++)
            init_state[32*(4+i) +: 32] = words[i];
        init_state[415:384]   = counter;
        for (int i = 0; i < NONCE_WORDS; i++)
            init_state[32*(13+i) +: 32] = words[KEY_WORDS+i];
        core_in_state = ((state == START) || (state == WAIT)) ? init_state : '0;
    end

endmodule

// File: tb/tb_chacha20_ctrl.sv
// Bench for chacha20_ctrl: acts as TRNG, host and ChaCha20 core, and checks
// every result against a behavioural model of the session and cipher.
`timescale 1ns/1ps
module tb_chacha20_ctrl;

    localparam int QI [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                                 '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rekey = 1'b0;
    logic         mode = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [511:0] in_data = '0;
    logic         core_busy = 1'b0;
    logic         core_done = 1'b0;
    logic [511:0] core_out_state = '0;
    logic [31:0]  trng_data = '0;
    logic         trng_ready = 1'b0;
    logic         keyed, busy, err_trng, err_ctr, in_ready, out_valid;
    logic         core_start, core_mode, trng_request;
    logic [511:0] out_data, core_in_state;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  done_cyc = 0;
    bit  abort_blk = 1'b0;

    logic [31:0]  m_key [8];
    logic [31:0]  m_nonce [3];
    logic [31:0]  m_ctr = '0;
    logic         m_err_ctr = 1'b0;
    logic [31:0]  wv [11];
    logic [511:0] last_out, last_st, cap;
    bit           flag;

    chacha20_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rekey(rekey), .mode(mode), .keyed(keyed), .busy(busy),
        .err_trng(err_trng), .err_ctr(err_ctr), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
        .core_mode(core_mode), .core_in_state(core_in_state), .core_out_state(core_out_state),
        .trng_request(trng_request), .trng_data(trng_data), .trng_ready(trng_ready)
    );

    always #5 clk = ~clk;

    // free-running cycle count for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a0, b0, c0, d0);
        logic [31:0] a, b, c, d;
        a = a0; b = b0; c = c0; d = d0;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] chacha_block(input logic [511:0] st);
        logic [31:0]  x [16];
        logic [127:0] r;
        logic [511:0] o;
        for (int i = 0; i < 16; i++) x[i] = st[32*i +: 32];
        for (int rnd = 0; rnd < 10; rnd++) begin
            for (int q = 0; q < 8; q++) begin
                r = qr(x[QI[q][0]], x[QI[q][1]], x[QI[q][2]], x[QI[q][3]]);
                x[QI[q][0]] = r[127:96];
                x[QI[q][1]] = r[95:64];
                x[QI[q][2]] = r[63:32];
                x[QI[q][3]] = r[31:0];
            end
        end
        for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + st[32*i +: 32];
        return o;
    endfunction

    function automatic logic [511:0] m_state();
        logic [511:0] s;
        s = '0;
        s[31:0]   = 32'h61707865;
        s[63:32]  = 32'h3320646e;
        s[95:64]  = 32'h79622d32;
        s[127:96] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[128 + 32*i +: 32] = m_key[i];
        s[415:384] = m_ctr;
        for (int i = 0; i < 3; i++) s[416 + 32*i +: 32] = m_nonce[i];
        return s;
    endfunction

    // core model: random latency, real ChaCha20 keystream
    initial begin
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                cap = core_in_state;
                @(posedge clk);
                #1 core_busy = 1'b1;
                repeat ($urandom_range(1, 6)) @(negedge clk);
                if (!abort_blk) chk("in_state_stable", core_in_state, cap);
                core_out_state = chacha_block(cap);
                core_busy = 1'b0;
                core_done = 1'b1;
                done_cyc  = cyc;
                @(negedge clk);
                core_done = 1'b0;
                core_out_state = {16{$urandom}};
            end
        end
    end

    task automatic do_fetch(input bit pulse, input int stall_idx, input int stall_len, input int restart_at);
        int i = 0;
        int si = stall_idx;
        int rs = restart_at;
        if (pulse) begin
            rekey = 1'b1;
            @(negedge clk);
            rekey = 1'b0;
        end
        chk("fetch_req", trng_request, 1'b1);
        chk("fetch_err_trng_clr", err_trng, 1'b0);
        while (i < 11) begin
            if (i == rs) begin
                rs = -1;
                trng_ready = 1'b0;
                rekey = 1'b1;
                @(negedge clk);
                rekey = 1'b0;
                i = 0;
            end else if (i == si) begin
                si = -1;
                trng_ready = 1'b0;
                repeat (stall_len) @(negedge clk);
                if (stall_len >= 1024) begin
                    chk("timeout_err_trng", err_trng, 1'b1);
                    chk("timeout_req", trng_request, 1'b0);
                    chk("timeout_busy", busy, 1'b0);
                    chk("timeout_keyed", keyed, 1'b0);
                    chk("timeout_in_ready", in_ready, 1'b0);
                    return;
                end
            end else begin
                trng_ready = 1'b1;
                trng_data  = wv[i];
                @(negedge clk);
                i++;
            end
        end
        trng_ready = 1'b0;
        trng_data  = $urandom;
        for (int k = 0; k < 8; k++) m_key[k] = wv[k];
        for (int k = 0; k < 3; k++) m_nonce[k] = wv[8+k];
        m_ctr = 32'd1;
        m_err_ctr = 1'b0;
        chk("fetch_keyed", keyed, 1'b1);
        chk("fetch_req_drop", trng_request, 1'b0);
        chk("fetch_err_ctr", err_ctr, m_err_ctr);
        chk("fetch_in_ready", in_ready, 1'b1);
    endtask

    task automatic send_block(input logic [511:0] d, input int hold, input bit rk_wait);
        logic [511:0] exp_st, exp_out;
        int n;
        bit stable, exhaust;
        logic md;
        md = 1'($urandom);
        chk("blk_in_ready", in_ready, 1'b1);
        mode = md;
        in_valid = 1'b1;
        in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data = {16{$urandom}};
        exp_st = m_state();
        last_st = core_in_state;
        chk("start_pulse", core_start, 1'b1);
        chk("start_state", core_in_state, exp_st);
        chk("core_mode", core_mode, md);
        chk("start_busy", busy, 1'b1);
        chk("start_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("start_one_cycle", core_start, 1'b0);
        if (rk_wait) begin
            rekey = 1'b1;
            @(negedge clk);
            rekey = 1'b0;
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid", out_valid, 1'b1);
        chk("out_latency", cyc - done_cyc, 1);
        exp_out = d ^ chacha_block(exp_st);
        last_out = out_data;
        chk("out_data", out_data, exp_out);
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== exp_out || in_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) chk("hold_stable", stable, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exhaust = (m_ctr == 32'hFFFFFFFF);
        if (exhaust) m_err_ctr = 1'b1;
        else         m_ctr = m_ctr + 1;
        chk("post_out_valid", out_valid, 1'b0);
        if (rk_wait) begin
            chk("pend_fetch_req", trng_request, 1'b1);
            chk("pend_busy", busy, 1'b1);
            chk("pend_keyed", keyed, 1'b0);
        end else if (exhaust) begin
            chk("exh_err_ctr", err_ctr, 1'b1);
            chk("exh_keyed", keyed, 1'b0);
            chk("exh_in_ready", in_ready, 1'b0);
            chk("exh_busy", busy, 1'b0);
        end else begin
            chk("next_keyed", keyed, 1'b1);
            chk("next_in_ready", in_ready, 1'b1);
            chk("next_err_ctr", err_ctr, m_err_ctr);
        end
    endtask

    // safety net against a hung handshake
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // main stimulus
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {keyed, busy, err_trng, err_ctr, in_ready, out_valid, core_start, trng_request}, 8'h00);
        chk("rst_out_data", out_data, '0);
        chk("rst_in_state", core_in_state, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_req", trng_request, 1'b0);

        // RFC 8439 block-function vector, with a 1023-cycle TRNG stall mid-fetch
        for (int i = 0; i < 8; i++) wv[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        wv[8] = 32'h09000000;
        wv[9] = 32'h4a000000;
        wv[10] = 32'h00000000;
        do_fetch(1'b1, 4, 1023, -1);
        send_block('0, 0, 1'b0);
        chk("rfc_ks0", last_out[31:0], 32'he4e7f110);
        chk("rfc_s12", last_st[415:384], 32'd1);

        // fresh session with a restart mid-fetch, three back-to-back blocks, then backpressure
        for (int i = 0; i < 11; i++) wv[i] = $urandom;
        do_fetch(1'b1, -1, 0, 3);
        for (int k = 0; k < 3; k++) begin
            send_block({16{$urandom}}, 0, 1'b0);
            chk("s12_seq", last_st[415:384], k + 1);
        end
        send_block({16{$urandom}}, 50, 1'b0);

        // TRNG timeout, then a block offered in ERROR must be ignored
        for (int i = 0; i < 11; i++) wv[i] = $urandom;
        do_fetch(1'b1, 5, 1024, -1);
        flag = 1'b0;
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (core_start !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) flag = 1'b1;
        end
        in_valid = 1'b0;
        chk("error_ignores_block", flag, 1'b0);

        // counter exhaustion, then recovery by rekey
        for (int i = 0; i < 11; i++) wv[i] = $urandom;
        do_fetch(1'b1, -1, 0, -1);
        force dut.counter = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.counter;
        m_ctr = 32'hFFFFFFFF;
        send_block({16{$urandom}}, 2, 1'b0);
        for (int i = 0; i < 11; i++) wv[i] = $urandom;
        do_fetch(1'b1, -1, 0, -1);
        send_block({16{$urandom}}, 0, 1'b0);
        chk("recover_s12", last_st[415:384], 32'd1);

        // rekey during WAIT is deferred until after the output handshake
        send_block({16{$urandom}}, 3, 1'b1);
        for (int i = 0; i < 11; i++) wv[i] = $urandom;
        do_fetch(1'b0, -1, 0, -1);

        // random traffic
        repeat (4) send_block({16{$urandom}}, $urandom_range(0, 5), 1'b0);

        // reset while the core is running
        mode = 1'b0;
        in_valid = 1'b1;
        in_data = {16{$urandom}};
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_test_start", core_start, 1'b1);
        @(negedge clk);
        abort_blk = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {keyed, busy, err_trng, err_ctr, in_ready, out_valid, core_start, trng_request, core_mode}, 9'h000);
        chk("midrst_out_data", out_data, '0);
        chk("midrst_in_state", core_in_state, '0);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0 || keyed !== 1'b0) flag = 1'b1;
        end
        chk("midrst_no_output", flag, 1'b0);
        abort_blk = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
